// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller beside the ID stage of the 5-stage MIPS pipeline.
// Define PIPE_CTRL_MULDIV_EN to build in the multiply/divide stall sequencer (MD_WAIT, md_cnt).
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES = 8,
  parameter int PERF_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        id_rs_i,
  input  logic [4:0]        id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              id_md_i,
  input  logic              ex_memread_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              branch_taken_i,
  output logic              pc_write_o,
  output logic              if_id_keep_o,
  output logic              if_id_clear_o,
  output logic              id_ex_clear_o,
  output logic              md_go_o,
  output logic              md_abort_o,
  output logic              md_busy_o,
  output logic [PERF_W-1:0] stall_cnt_o,
  output logic [PERF_W-1:0] flush_cnt_o
);

  localparam logic [PERF_W-1:0] CNT_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    sat_inc = (v == {PERF_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  logic rs_hit;
  logic rt_hit;
  logic load_use;

  assign rs_hit   = (ex_rd_i == id_rs_i);
  assign rt_hit   = id_uses_rt_i && (ex_rd_i == id_rt_i);
  assign load_use = ex_memread_i && (ex_rd_i != 5'd0) && (rs_hit || rt_hit);

`ifdef PIPE_CTRL_MULDIV_EN

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam logic [5:0] MD_LOAD = 6'(MD_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] md_cnt_q;
  logic [5:0] md_cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RUN;
      md_cnt_q <= 6'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // The reset branch keeps the pipeline flushed and the PC frozen while rst_i is high.
  always_comb begin
    state_d       = state_q;
    md_cnt_d      = md_cnt_q;
    pc_write_o    = 1'b1;
    if_id_keep_o  = 1'b0;
    if_id_clear_o = 1'b0;
    id_ex_clear_o = 1'b0;
    md_go_o       = 1'b0;
    md_abort_o    = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      if_id_clear_o = 1'b1;
      id_ex_clear_o = 1'b1;
    end else if (branch_taken_i) begin
      if_id_clear_o = 1'b1;
      id_ex_clear_o = 1'b1;
      md_abort_o    = (state_q == MD_WAIT);
      state_d       = RUN;
      md_cnt_d      = 6'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (load_use) begin
            pc_write_o    = 1'b0;
            if_id_keep_o  = 1'b1;
            id_ex_clear_o = 1'b1;
          end else if (id_md_i) begin
            pc_write_o    = 1'b0;
            if_id_keep_o  = 1'b1;
            id_ex_clear_o = 1'b1;
            md_go_o       = 1'b1;
            state_d       = MD_WAIT;
            md_cnt_d      = MD_LOAD;
          end
        end
        MD_WAIT: begin
          // md_cnt == 0 is the release cycle: the mul/div instruction leaves ID.
          if (md_cnt_q != 6'd0) begin
            pc_write_o    = 1'b0;
            if_id_keep_o  = 1'b1;
            id_ex_clear_o = 1'b1;
            md_cnt_d      = md_cnt_q - 6'd1;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d  = RUN;
          md_cnt_d = 6'd0;
        end
      endcase
    end
  end

  assign md_busy_o = (state_q == MD_WAIT);

`else

  logic unused_md;
  assign unused_md = id_md_i;

  always_comb begin
    pc_write_o    = 1'b1;
    if_id_keep_o  = 1'b0;
    if_id_clear_o = 1'b0;
    id_ex_clear_o = 1'b0;
    if (rst_i) begin
      pc_write_o    = 1'b0;
      if_id_clear_o = 1'b1;
      id_ex_clear_o = 1'b1;
    end else if (branch_taken_i) begin
      if_id_clear_o = 1'b1;
      id_ex_clear_o = 1'b1;
    end else if (load_use) begin
      pc_write_o    = 1'b0;
      if_id_keep_o  = 1'b1;
      id_ex_clear_o = 1'b1;
    end
  end

  assign md_go_o    = 1'b0;
  assign md_abort_o = 1'b0;
  assign md_busy_o  = 1'b0;

`endif

  logic [PERF_W-1:0] stall_cnt_q;
  logic [PERF_W-1:0] flush_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_write_o) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if (branch_taken_i) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MD_CYCLES=8, PERF_W=4 to exercise saturation).
module tb_pipeline_hazard_ctrl;

  localparam int MD_CYCLES = 8;
  localparam int PERF_W    = 4;
  localparam int CNT_MAX   = (1 << PERF_W) - 1;

`ifdef PIPE_CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [4:0]        id_rs_i, id_rt_i, ex_rd_i;
  logic              id_uses_rt_i, id_md_i, ex_memread_i, branch_taken_i;
  logic              pc_write_o, if_id_keep_o, if_id_clear_o, id_ex_clear_o;
  logic              md_go_o, md_abort_o, md_busy_o;
  logic [PERF_W-1:0] stall_cnt_o, flush_cnt_o;

  pipeline_hazard_ctrl #(.MD_CYCLES(MD_CYCLES), .PERF_W(PERF_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rt_i(id_uses_rt_i), .id_md_i(id_md_i),
    .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i), .branch_taken_i(branch_taken_i),
    .pc_write_o(pc_write_o), .if_id_keep_o(if_id_keep_o), .if_id_clear_o(if_id_clear_o),
    .id_ex_clear_o(id_ex_clear_o), .md_go_o(md_go_o), .md_abort_o(md_abort_o),
    .md_busy_o(md_busy_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // {pc_write, if_id_keep, if_id_clear, id_ex_clear, md_go, md_abort}
  typedef struct packed {
    logic [5:0]        ctl;
    logic              busy;
    logic [PERF_W-1:0] sc;
    logic [PERF_W-1:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // reference model state
  bit m_md;
  int m_cnt, m_sc, m_fc;
  int n_md, n_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] dut_ctl();
    return {pc_write_o, if_id_keep_o, if_id_clear_o, id_ex_clear_o, md_go_o, md_abort_o};
  endfunction

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    m_md = 0; m_cnt = 0; m_sc = 0; m_fc = 0;
  endtask

  // Expected combinational controls for the current inputs; also sets n_md/n_cnt.
  function automatic logic [5:0] model_ctl();
    logic pc, keep, ifc, idc, go, ab, lu;
    pc = 1; keep = 0; ifc = 0; idc = 0; go = 0; ab = 0;
    n_md = m_md; n_cnt = m_cnt;
    lu = ex_memread_i && (ex_rd_i != 0) &&
         ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));
    if (branch_taken_i) begin
      ifc = 1; idc = 1; ab = m_md; n_md = 0; n_cnt = 0;
    end else if (m_md) begin
      if (m_cnt != 0) begin
        pc = 0; keep = 1; idc = 1; n_cnt = m_cnt - 1;
      end else begin
        n_md = 0;
      end
    end else if (lu) begin
      pc = 0; keep = 1; idc = 1;
    end else if (id_md_i && MD_EN) begin
      pc = 0; keep = 1; idc = 1; go = 1; n_md = 1; n_cnt = MD_CYCLES - 1;
    end
    return {pc, keep, ifc, idc, go, ab};
  endfunction

  task automatic set_in(input logic br, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic md);
    branch_taken_i = br; ex_memread_i = mr; ex_rd_i = rd;
    id_rs_i = rs; id_rt_i = rt; id_uses_rt_i = urt; id_md_i = md;
  endtask

  // Called just after a rising edge: drive, predict, compare at the falling edge, advance model.
  task automatic step(input string tag, input logic br, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic md);
    exp_t e, got_e;
    string t;
    set_in(br, mr, rd, rs, rt, urt, md);
    e.ctl  = model_ctl();
    e.busy = m_md;
    e.sc   = PERF_W'(m_sc);
    e.fc   = PERF_W'(m_fc);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk_i);
    if (exp_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got_e = exp_q.pop_front();
      t     = tag_q.pop_front();
      check_val({t, ".ctl"},   32'(dut_ctl()),   32'(got_e.ctl));
      check_val({t, ".busy"},  32'(md_busy_o),   32'(got_e.busy));
      check_val({t, ".stall"}, 32'(stall_cnt_o), 32'(got_e.sc));
      check_val({t, ".flush"}, 32'(flush_cnt_o), 32'(got_e.fc));
    end
    if (!e.ctl[5]) m_sc = sat(m_sc);
    if (br) m_fc = sat(m_fc);
    m_md = n_md[0]; m_cnt = n_cnt;
    @(posedge clk_i); #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".ctl"},   32'(dut_ctl()),   32'b001100);
    check_val({tag, ".busy"},  32'(md_busy_o),   32'd0);
    check_val({tag, ".stall"}, 32'(stall_cnt_o), 32'd0);
    check_val({tag, ".flush"}, 32'(flush_cnt_o), 32'd0);
  endtask

  // Assert reset asynchronously mid-cycle, check outputs before the next edge, then release.
  task automatic do_reset(input string tag);
    #2 rst_i = 1'b1;
    #1 check_reset_outputs(tag);
    set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  initial begin
    rst_i = 1'b1;
    set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    model_reset();
    @(posedge clk_i); #1;
    check_reset_outputs("reset_init");
    @(negedge clk_i) rst_i = 1'b0;
    @(posedge clk_i); #1;

    idle("idle0");
    step("load_use_rs", 0, 1, 5'd8, 5'd8, 5'd3, 0, 0);
    check_val("load_use_cnt", 32'(stall_cnt_o), 32'd1);
    step("zero_reg", 0, 1, 5'd0, 5'd0, 5'd0, 1, 0);
    step("rt_unused", 0, 1, 5'd9, 5'd3, 5'd9, 0, 0);
    step("rt_used", 0, 1, 5'd9, 5'd3, 5'd9, 1, 0);
    step("no_load", 0, 0, 5'd9, 5'd9, 5'd9, 1, 0);
    check_val("lu_total", 32'(stall_cnt_o), 32'd2);

    // mul/div held for T..T+8, then released
    do_reset("reset_a");
    for (int i = 0; i <= MD_CYCLES; i++) step($sformatf("md_%0d", i), 0, 0, 5'd0, 5'd1, 5'd2, 1, 1);
    idle("md_after");
`ifdef PIPE_CTRL_MULDIV_EN
    check_val("md_stall_total", 32'(stall_cnt_o), 32'(MD_CYCLES));
`else
    check_val("md_stall_total", 32'(stall_cnt_o), 32'd0);
`endif

    // branch at T+3 during MD_WAIT
    do_reset("reset_b");
    for (int i = 0; i < 3; i++) step($sformatf("mdb_%0d", i), 0, 0, 5'd0, 5'd1, 5'd2, 1, i == 0);
    step("md_branch", 1, 0, 5'd0, 5'd1, 5'd2, 1, 0);
    idle("md_branch_after");
    check_val("md_branch_flush", 32'(flush_cnt_o), 32'd1);
    check_val("md_branch_busy", 32'(md_busy_o), 32'd0);

    // priority
    step("all_three", 1, 1, 5'd4, 5'd4, 5'd0, 0, 1);
    step("lu_and_md", 0, 1, 5'd4, 5'd4, 5'd0, 0, 1);
    step("md_next", 0, 0, 5'd4, 5'd4, 5'd0, 0, 1);
    step("md_wait1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

    // reset while in MD_WAIT: no abort, outputs at reset values before the next edge
    do_reset("reset_mid_md");
    idle("after_reset_mid");

    // saturation
    for (int i = 0; i < 20; i++) step("sat_stall", 0, 1, 5'd7, 5'd7, 5'd0, 0, 0);
    idle("sat_stall_done");
    check_val("sat_stall_val", 32'(stall_cnt_o), 32'd15);
    for (int i = 0; i < 20; i++) step("sat_flush", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    check_val("sat_flush_val", 32'(flush_cnt_o), 32'd15);

    // random traffic with a reset in the middle
    do_reset("reset_c");
    for (int i = 0; i < 300; i++) begin
      if (i == 150) do_reset("reset_rand");
      step("rand", ($urandom_range(0, 9) == 0), $urandom_range(0, 1),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1), ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Drives the IF/ID pipeline register's keep/clear controls, the PC write enable and the ID/EX bubble insert, based on load-use hazards, taken branches/jumps and multi-cycle multiply/divide stalls. Sits beside the ID stage, between decode, the EX-stage branch resolution and the PC/IF/ID register bank. Also keeps saturating stall and flush performance counters.

## Interface
- MD_CYCLES, 8: stall cycles per multiply/divide; legal range 2..63.
- PERF_W, 32: width of each performance counter.

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- id_rs_i  in  5  rs field of the instruction in ID.
- id_rt_i  in  5  rt field of the instruction in ID.
- id_uses_rt_i  in  1  ID instruction reads rt.
- id_md_i  in  1  ID instruction is mult/multu/div/divu.
- ex_memread_i  in  1  EX instruction is a load.
- ex_rd_i  in  5  destination register of the EX instruction.
- branch_taken_i  in  1  EX-resolved taken branch or jump this cycle.
- pc_write_o  out  1  PC load enable.
- if_id_keep_o  out  1  hold IF/ID contents.
- if_id_clear_o  out  1  zero IF/ID contents.
- id_ex_clear_o  out  1  insert bubble into ID/EX.
- md_go_o  out  1  one-cycle start pulse to the mul/div unit.
- md_abort_o  out  1  one-cycle abort pulse to the mul/div unit.
- md_busy_o  out  1  registered; high while in MD_WAIT.
- stall_cnt_o  out  PERF_W  stall cycles counted.
- flush_cnt_o  out  PERF_W  flush cycles counted.

## Operation
- States: RUN, MD_WAIT. Down-counter md_cnt, 6 bits.
- load_use = ex_memread_i & (ex_rd_i != 0) & ((ex_rd_i == id_rs_i) | (id_uses_rt_i & (ex_rd_i == id_rt_i))).
- Priority, highest first: branch_taken_i, load_use, mul/div.
- Flush (branch_taken_i=1, any state): pc_write_o=1, if_id_clear_o=1, if_id_keep_o=0, id_ex_clear_o=1. In MD_WAIT: md_abort_o=1, state -> RUN, md_cnt -> 0.
- Load-use (RUN, no flush): pc_write_o=0, if_id_keep_o=1, id_ex_clear_o=1, if_id_clear_o=0. State stays RUN. An id_md_i in the same cycle is ignored and re-evaluated next cycle.
- MD entry (RUN, id_md_i=1, no flush, no load_use): stall as for load-use, md_go_o=1, state -> MD_WAIT, md_cnt -> MD_CYCLES-1.
- MD_WAIT, md_cnt != 0, no flush: stall outputs as for load-use, md_cnt decrements.
- MD_WAIT, md_cnt == 0, no flush: release cycle with all controls idle, state -> RUN. id_md_i and load_use are ignored in this cycle; the instruction advances.
- Idle (none of the above): pc_write_o=1, all other controls 0.
- stall_cnt_o increments in every cycle with pc_write_o=0. flush_cnt_o increments in every cycle with branch_taken_i=1. Both saturate at all-ones and never wrap.

## Timing
- pc_write_o, if_id_keep_o, if_id_clear_o, id_ex_clear_o, md_go_o and md_abort_o are combinational from state and inputs in the same cycle.
- md_busy_o, the counters and md_cnt are registered.
- Mul/div stall length: md_go_o in cycle T. Stalls in T through T+MD_CYCLES-1, which is exactly MD_CYCLES cycles. Release in T+MD_CYCLES.
- While rst_i=1, asynchronously: state=RUN, md_cnt=0, md_busy_o=0, stall_cnt_o=0, flush_cnt_o=0, pc_write_o=0, if_id_keep_o=0, if_id_clear_o=1, id_ex_clear_o=1, md_go_o=0, md_abort_o=0.
- Reset asserted mid-MD_WAIT: no md_abort_o pulse. The mul/div unit is reset by the same rst_i.
- The first edge after rst_i deasserts operates normally from RUN.

## Configuration
- PIPE_CTRL_MULDIV_EN defined: MD_WAIT state, md_cnt, md_go_o and md_abort_o behave as above.
- PIPE_CTRL_MULDIV_EN undefined: id_md_i is ignored, the state machine is removed, and md_go_o, md_abort_o and md_busy_o are tied 0. Load-use, flush and the counters are unchanged.

## Test plan
- Load-use: ex_memread_i=1, ex_rd_i=8, id_rs_i=8 for one cycle. Required: pc_write_o=0, if_id_keep_o=1, id_ex_clear_o=1 for that cycle; stall_cnt_o=1 next cycle.
- Zero register: ex_memread_i=1, ex_rd_i=0, id_rs_i=0. Required: no stall, pc_write_o=1. Also id_uses_rt_i=0 with an rt-only match: no stall.
- Mul/div with MD_CYCLES=8: id_md_i=1 held. Required: md_go_o pulse at T, 8 stall cycles, release at T+8, md_busy_o high T+1..T+8, stall_cnt_o=8.
- Branch in MD_WAIT: branch_taken_i=1 at T+3. Required: md_abort_o=1, IF/ID and ID/EX cleared, pc_write_o=1, RUN at T+4, flush_cnt_o=1.
- Simultaneous load_use, id_md_i and branch_taken_i: flush wins with no md_go_o. Load_use with id_md_i: load-use stall first, md_go_o next cycle.
- Saturation with PERF_W=4: 20 stall cycles leave stall_cnt_o=15. Reset asserted mid-MD_WAIT: all outputs at reset values immediately, before the next clock edge.
